// File: rtl/common.sv
// Shared definitions for the flash loader.
//   loader_state_t  : loader FSM states
//   LOADER_SYNC_HDR : default byte that opens a write frame
//   LOADER_END_HDR  : default byte that ends loading and releases the core
package common;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

    localparam logic [7:0] LOADER_SYNC_HDR = 8'hA5;
    localparam logic [7:0] LOADER_END_HDR  = 8'h5A;

endpackage

// File: rtl/byte_shift_reg.sv
// Little-endian word assembler. Each loaded byte enters at the top and the
// word shifts down by one byte, so after WIDTH/8 loads the first byte sits
// in bits [7:0].
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clr_i   : clear the word (takes priority over load)
//   load_i  : shift byte_i in
//   byte_i  : incoming byte
//   word_o  : assembled word
module byte_shift_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else if (clr_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= {byte_i, word_q[WIDTH-1:8]};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/flash_loader.sv
// Bootloader front end: turns a byte stream into flash word writes and holds
// the core in reset until the host sends the end-of-load byte.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_data    : stream byte
//   in_valid   : in_data valid
//   in_ready   : loader accepts a byte (low only in the write cycle)
//   flash_addr : write byte address
//   flash_data : write data
//   flash_en   : one-cycle write strobe
//   hold_rst   : 1 = core held in reset
//   done       : loading finished, core released
//   err        : sticky protocol error
//   word_count : writes issued, saturating
module flash_loader
    import common::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter logic [7:0]  SYNC_HDR = LOADER_SYNC_HDR,
    parameter logic [7:0]  END_HDR  = LOADER_END_HDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             flash_en,
    output logic             hold_rst,
    output logic             done,
    output logic             err,
    output logic [15:0]      word_count
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

    loader_state_t    state_q;
    logic [IDX_W-1:0] idx_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] flash_addr_q;
    logic [WIDTH-1:0] flash_data_q;
    logic             flash_en_q;
    logic             hold_rst_q;
    logic             done_q;
    logic             err_q;
    logic [15:0]      word_count_q;

    logic             in_fire;
    logic             frame_start;
    logic [WIDTH-1:0] addr_word;
    logic [WIDTH-1:0] data_word;
    logic [WIDTH-1:0] data_d;

    assign in_fire     = in_valid & in_ready_q;
    assign frame_start = in_fire && (in_data == SYNC_HDR) &&
                         ((state_q == ST_IDLE) || (state_q == ST_DONE));

    byte_shift_reg #(.WIDTH(WIDTH)) u_addr_sr (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (frame_start),
        .load_i (in_fire && (state_q == ST_ADDR)),
        .byte_i (in_data),
        .word_o (addr_word)
    );

    byte_shift_reg #(.WIDTH(WIDTH)) u_data_sr (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (frame_start),
        .load_i (in_fire && (state_q == ST_DATA)),
        .byte_i (in_data),
        .word_o (data_word)
    );

    // The data register only holds the final byte after the accepting edge,
    // so the write data is formed here to launch the strobe on that same edge.
    assign data_d = {in_data, data_word[WIDTH-1:8]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            in_ready_q   <= 1'b1;
            flash_addr_q <= '0;
            flash_data_q <= '0;
            flash_en_q   <= 1'b0;
            hold_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            flash_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        if (in_data == SYNC_HDR) begin
                            state_q <= ST_ADDR;
                            idx_q   <= '0;
                        end else if (in_data == END_HDR) begin
                            state_q    <= ST_DONE;
                            hold_rst_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (in_fire) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
                            state_q <= ST_DATA;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (in_fire) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            if (addr_word[1:0] == 2'b00) begin
                                state_q      <= ST_WRITE;
                                flash_en_q   <= 1'b1;
                                in_ready_q   <= 1'b0;
                                flash_addr_q <= addr_word;
                                flash_data_q <= data_d;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                    if (word_count_q != '1) begin
                        word_count_q <= word_count_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (in_fire && (in_data == SYNC_HDR)) begin
                        state_q    <= ST_ADDR;
                        idx_q      <= '0;
                        hold_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign flash_en   = flash_en_q;
    assign hold_rst   = hold_rst_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_flash_loader.sv
module tb_flash_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        flash_en;
    logic        hold_rst;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          pulses = 0;
    int          rdy_bad = 0;
    int          stamp [64];
    logic [31:0] seen_addr [64];
    logic [31:0] seen_data [64];

    flash_loader #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .flash_en   (flash_en),
        .hold_rst   (hold_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder and in_ready/flash_en relation watcher.
    always @(negedge clk) begin
        if (rst) begin
            if (flash_en) begin
                if (pulses < 64) begin
                    stamp[pulses]     = cyc;
                    seen_addr[pulses] = flash_addr;
                    seen_data[pulses] = flash_data;
                end
                pulses = pulses + 1;
            end
            if (in_ready == flash_en) rdy_bad = rdy_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Present a byte after an optional gap and wait (bounded) for its transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d, input bit stall);
        send_byte(8'hA5, stall ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < 4; i++)
            send_byte(8'(a >> (8 * i)), stall ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < 4; i++)
            send_byte(8'(d >> (8 * i)), stall ? int'($urandom_range(0, 3)) : 0);
    endtask

    // Drop valid and let a pending strobe and count update complete.
    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [7:0]  t1 [9];
    logic [31:0] t2_data [4];
    int          p0;

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        t1 = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h16, 8'h00, 8'hEF, 8'hBE};
        t2_data = '{32'h01002083, 32'h01402103, 32'h01802183, 32'h01c02203};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flash_en", 32'(flash_en), 32'd0);
        check("rst_hold_rst", 32'(hold_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_flash_addr", flash_addr, 32'd0);
        rst = 1'b1;

        // Single write
        p0 = pulses;
        foreach (t1[i]) send_byte(t1[i], 0);
        settle();
        check("t1_pulses", 32'(pulses - p0), 32'd1);
        check("t1_addr", seen_addr[p0], 32'h00000010);
        check("t1_data", seen_data[p0], 32'hBEEF0016);
        check("t1_word_count", 32'(word_count), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // Four back-to-back frames at full rate
        do_reset();
        p0      = pulses;
        rdy_bad = 0;
        for (int f = 0; f < 4; f++) send_frame(32'(4 * f), t2_data[f], 1'b0);
        settle();
        check("t2_pulses", 32'(pulses - p0), 32'd4);
        for (int f = 0; f < 4; f++) begin
            check("t2_addr", seen_addr[p0 + f], 32'(4 * f));
            check("t2_data", seen_data[p0 + f], t2_data[f]);
        end
        for (int f = 1; f < 4; f++)
            check("t2_spacing", 32'(stamp[p0 + f] - stamp[p0 + f - 1]), 32'd10);
        check("t2_in_ready_vs_strobe", 32'(rdy_bad), 32'd0);
        check("t2_word_count", 32'(word_count), 32'd4);

        // Misaligned address, then a valid frame still writes
        p0 = pulses;
        send_frame(32'h00000011, 32'hDEADBEEF, 1'b0);
        settle();
        check("mis_pulses", 32'(pulses - p0), 32'd0);
        check("mis_err", 32'(err), 32'd1);
        send_frame(32'h00000020, 32'hCAFEF00D, 1'b0);
        settle();
        check("mis_next_pulses", 32'(pulses - p0), 32'd1);
        check("mis_next_addr", seen_addr[p0], 32'h00000020);
        check("mis_next_data", seen_data[p0], 32'hCAFEF00D);
        check("mis_word_count", 32'(word_count), 32'd5);

        // Bad header in IDLE
        do_reset();
        check("hdr_err_before", 32'(err), 32'd0);
        send_byte(8'h33, 0);
        settle();
        check("hdr_err", 32'(err), 32'd1);
        check("hdr_hold_rst", 32'(hold_rst), 32'd1);

        // End and reload
        do_reset();
        check("end_hold_before", 32'(hold_rst), 32'd1);
        send_byte(8'h5A, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("end_hold_rst", 32'(hold_rst), 32'd0);
        check("end_done", 32'(done), 32'd1);
        send_byte(8'h77, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("end_ignore_done", 32'(done), 32'd1);
        check("end_ignore_err", 32'(err), 32'd0);
        p0 = pulses;
        send_byte(8'hA5, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("reload_hold_rst", 32'(hold_rst), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(32'h00000040 >> (8 * i)), 0);
        for (int i = 0; i < 4; i++) send_byte(8'(32'h12345678 >> (8 * i)), 0);
        settle();
        check("reload_pulses", 32'(pulses - p0), 32'd1);
        check("reload_addr", seen_addr[p0], 32'h00000040);
        check("reload_data", seen_data[p0], 32'h12345678);

        // Stalled frame matches the unstalled result
        do_reset();
        p0 = pulses;
        send_frame(32'h00000010, 32'hBEEF0016, 1'b1);
        settle();
        check("stall_pulses", 32'(pulses - p0), 32'd1);
        check("stall_addr", seen_addr[p0], 32'h00000010);
        check("stall_data", seen_data[p0], 32'hBEEF0016);
        check("stall_word_count", 32'(word_count), 32'd1);

        // Reset after 5 bytes of a frame
        send_byte(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h08 + 8'(i), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_addr", flash_addr, 32'd0);
        check("mid_rst_data", flash_data, 32'd0);
        check("mid_rst_en", 32'(flash_en), 32'd0);
        check("mid_rst_hold", 32'(hold_rst), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        p0  = pulses;
        send_frame(32'h00000100, 32'hA1B2C3D4, 1'b0);
        settle();
        check("post_rst_pulses", 32'(pulses - p0), 32'd1);
        check("post_rst_addr", seen_addr[p0], 32'h00000100);
        check("post_rst_data", seen_data[p0], 32'hA1B2C3D4);
        check("post_rst_count", 32'(word_count), 32'd1);

        // Saturation
        @(negedge clk);
        force dut.word_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.word_count_q;
        @(negedge clk);
        check("sat_preset", 32'(word_count), 32'h0000FFFF);
        p0 = pulses;
        send_frame(32'h00000200, 32'h0BADC0DE, 1'b0);
        settle();
        check("sat_pulses", 32'(pulses - p0), 32'd1);
        check("sat_word_count", 32'(word_count), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
